ir_burst_txrx: RTL

//  Parametrised IR link front end. TX side generates a square-wave carrier, gated into repeating
//  on/off bursts, with a runtime-selectable carrier divider. RX side measures the low-pulse width of
//  the demodulated receiver output and flags pulses longer than a threshold on an LED output.
//  It sits between the board button/receiver pins and the IR LED driver.

---
 rtl/ir_pkg.sv | 14 +
 rtl/ir_pulse_meter.sv | 60 ++++++
 rtl/ir_burst_txrx.sv | 116 +++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and encodings for the IR burst transmitter / pulse-width receiver.
package ir_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_ON, TX_OFF} tx_state_t;

  localparam logic [1:0] MODE_DIV0 = 2'd0;
  localparam logic [1:0] MODE_DIV1 = 2'd1;
  localparam logic [1:0] MODE_DIV2 = 2'd2;
  localparam logic [1:0] MODE_MUTE = 2'd3;

  // Idle level of the active-low receiver line; also the LED's "short pulse" level.
  localparam logic RX_IDLE = 1'b1;

endpackage

// File: rtl/ir_pulse_meter.sv
// RX side: synchronises the receiver pin and measures each low pulse in clk cycles,
// flagging pulses longer than WIDTH_TH by driving led low.
module ir_pulse_meter
  import ir_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WIDTH_TH = 540
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [CNT_W-1:0] pulse_width,
  output logic             width_valid,
  output logic             led
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(WIDTH_TH);

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_p2;
  logic             fall;
  logic             rise;
  logic [CNT_W-1:0] cnt;

  // rx_p1 is the synchronised line; rx_p2 is its one-cycle history for edge detection.
  assign fall = rx_p2 & ~rx_p1;
  assign rise = ~rx_p2 & rx_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0       <= RX_IDLE;
      rx_p1       <= RX_IDLE;
      rx_p2       <= RX_IDLE;
      cnt         <= '0;
      pulse_width <= '0;
      width_valid <= 1'b0;
      led         <= RX_IDLE;
    end else begin
      rx_p0       <= rx_in;
      rx_p1       <= rx_p0;
      rx_p2       <= rx_p1;
      width_valid <= rise;
      // The first low cycle loads 1 so the captured count equals the number of low cycles.
      if (fall) begin
        cnt <= CNT_W'(1);
      end else if (rise) begin
        cnt <= '0;
      end else if (!rx_p1 && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rise) begin
        pulse_width <= cnt;
        led         <= !(cnt > TH);
      end
    end
  end

endmodule

// File: rtl/ir_burst_txrx.sv
// IR link front end: gated square-wave carrier bursts on tx_out and low-pulse width
// measurement of the demodulated receiver on the RX side.
module ir_burst_txrx
  import ir_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DIV_W     = 16,
  parameter int DIV0      = 800,
  parameter int DIV1      = 600,
  parameter int DIV2      = 400,
  parameter int BURST_ON  = 27000000,
  parameter int BURST_OFF = 27000000,
  parameter int WIDTH_TH  = 540
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [1:0]       mode,
  input  logic             rx_in,
  output logic             tx_out,
  output logic             burst_active,
  output logic [CNT_W-1:0] pulse_width,
  output logic             width_valid,
  output logic             led
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BURST_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BURST_OFF - 1);

  tx_state_t        state;
  logic [DIV_W-1:0] c;
  logic [CNT_W-1:0] b;
  logic [DIV_W-1:0] cur_div;
  logic             cur_mute;
  logic [DIV_W-1:0] div_now;
  logic             mute_now;
  logic             last_c;

  // mode only takes effect at the start of a carrier period; mid-period the latched values hold.
  always_comb begin
    div_now  = cur_div;
    mute_now = cur_mute;
    if (c == '0) begin
      mute_now = (mode == MODE_MUTE);
      case (mode)
        MODE_DIV1: div_now = DIV_W'(DIV1);
        MODE_DIV2: div_now = DIV_W'(DIV2);
        default:   div_now = DIV_W'(DIV0);
      endcase
    end
  end

  assign last_c = (c == div_now - DIV_W'(1));

  // Outputs are registered from the current state/counter, so tx_out and burst_active
  // share the same one-cycle lag and stay mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= TX_IDLE;
      c            <= '0;
      b            <= '0;
      cur_div      <= DIV_W'(DIV0);
      cur_mute     <= 1'b0;
      tx_out       <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      tx_out       <= 1'b0;
      burst_active <= 1'b0;
      unique case (state)
        TX_IDLE: begin
          c <= '0;
          b <= '0;
          if (tx_en) state <= TX_ON;
        end
        TX_ON: begin
          burst_active <= 1'b1;
          tx_out       <= !mute_now && (c < (div_now >> 1));
          cur_div      <= div_now;
          cur_mute     <= mute_now;
          c            <= last_c ? '0 : c + DIV_W'(1);
          b            <= b + CNT_W'(1);
          if (b == ON_LAST) begin
            state <= TX_OFF;
            b     <= '0;
            c     <= '0;
          end else if (last_c && !tx_en) begin
            // Dropping tx_en waits for the period boundary so no runt pulse is emitted.
            state <= TX_IDLE;
          end
        end
        TX_OFF: begin
          b <= b + CNT_W'(1);
          if (b == OFF_LAST) begin
            b     <= '0;
            c     <= '0;
            state <= tx_en ? TX_ON : TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  ir_pulse_meter #(
    .CNT_W    (CNT_W),
    .WIDTH_TH (WIDTH_TH)
  ) u_meter (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .pulse_width (pulse_width),
    .width_valid (width_valid),
    .led         (led)
  );

endmodule
